// File: rtl/axil_pkg.sv
// axil_pkg
//   Shared types for the AXI-Lite interconnect response routers.
//   resp_t          : AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   wr_resp_state_t : write-response router FSM states
//   idx_width()     : index width for an N-entry select, never narrower than 1 bit
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SLV = 2'd1,
      RESP     = 2'd2
   } wr_resp_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axil_wr_resp_router_if.sv
// axil_wr_resp_router_if
//   Bundles the write-issue handshake, the per-slave B channels and the
//   master-side B channel seen by axil_wr_resp_router.
//   Issue  : wr_start, slv_valid, busy
//   Slave B: s_axil_bvalid, s_axil_bresp, s_axil_bready (one lane per slave)
//   Master B: m_axil_bvalid, m_axil_bresp, m_axil_bready
//   modport slave  : the router's view
//   modport master : the surrounding interconnect / environment view
interface axil_wr_resp_router_if #(
   parameter int unsigned NUMBER_SLAVE = 4
);

   logic                         wr_start;
   logic [NUMBER_SLAVE-1:0]      slv_valid;
   logic                         busy;
   logic [NUMBER_SLAVE-1:0]      s_axil_bvalid;
   logic [NUMBER_SLAVE-1:0][1:0] s_axil_bresp;
   logic [NUMBER_SLAVE-1:0]      s_axil_bready;
   logic                         m_axil_bvalid;
   logic [1:0]                   m_axil_bresp;
   logic                         m_axil_bready;

   modport slave (
      input  wr_start, slv_valid, s_axil_bvalid, s_axil_bresp, m_axil_bready,
      output busy, s_axil_bready, m_axil_bvalid, m_axil_bresp
   );

   modport master (
      output wr_start, slv_valid, s_axil_bvalid, s_axil_bresp, m_axil_bready,
      input  busy, s_axil_bready, m_axil_bvalid, m_axil_bresp
   );

endinterface

// File: rtl/axil_prio_enc.sv
// axil_prio_enc
//   Priority encoder: index of the lowest set bit of vec, plus an any-set flag.
//   Shared by the read- and write-side response routers.
//   vec : request vector (WIDTH bits)
//   idx : index of the lowest set bit (0 when none set)
//   any : at least one bit of vec is set
module axil_prio_enc
   import axil_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned IDX_W = idx_width(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      any = |vec;
      // Scan high to low so the lowest set bit is the last one written.
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (vec[i]) idx = i[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/axil_wr_resp_router.sv
// axil_wr_resp_router
//   Write-response return path of the AXI-Lite priority interconnect.
//   Latches the decoded slave on wr_start, readies only that slave's B
//   channel, and returns its response (or a local DECERR when no slave
//   matched) on the master B channel from a register.
//   Ports:
//     aclk, aresetn : clock, asynchronous active-low reset
//     bus           : axil_wr_resp_router_if.slave (issue + slave B + master B)
//   Optional feature: define AXIL_WR_RESP_TIMEOUT_EN to force SLVERR after
//   TIMEOUT_CYCLES silent WAIT_SLV cycles and drain the late response.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no write in flight, waiting for wr_start
//   WAIT_SLV | bready raised to the selected slave, waiting for its bvalid
//   RESP     | registered response presented to the master until bready
module axil_wr_resp_router
   import axil_pkg::*;
#(
   parameter int unsigned NUMBER_SLAVE   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axil_wr_resp_router_if.slave  bus
);

   localparam int unsigned IDX_W = idx_width(NUMBER_SLAVE);

   wr_resp_state_t          state_q, state_d;
   logic [IDX_W-1:0]        sel_q, sel_d;
   resp_t                   resp_q, resp_d;
   logic [IDX_W-1:0]        enc_idx;
   logic                    enc_any;
   logic [NUMBER_SLAVE-1:0] sel_mask;
   logic                    slv_hit;
   logic                    accept;
   logic                    stale;
   logic                    tmo_hit;

   axil_prio_enc #(.WIDTH(NUMBER_SLAVE)) u_prio_enc (
      .vec (bus.slv_valid),
      .idx (enc_idx),
      .any (enc_any)
   );

   assign sel_mask = NUMBER_SLAVE'(1) << sel_q;
   assign slv_hit  = bus.s_axil_bvalid[sel_q];
   // A bvalid on a draining slave is the stale timed-out response, not ours.
   assign accept   = slv_hit && !stale;

`ifdef AXIL_WR_RESP_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
   logic [NUMBER_SLAVE-1:0] drain_q, drain_d;

   assign stale   = drain_q[sel_q];
   // Compare against N-1: the count reaches N on the same edge we leave.
   assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      drain_d   = drain_q & ~bus.s_axil_bvalid;
      if (state_q == IDLE) begin
         tmo_cnt_d = '0;
      end else if (state_q == WAIT_SLV && !accept) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
         if (tmo_hit) drain_d = drain_d | sel_mask;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tmo_cnt_q <= '0;
         drain_q   <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         drain_q   <= drain_d;
      end
   end

   assign bus.s_axil_bready = drain_q | ((state_q == WAIT_SLV) ? sel_mask : '0);
`else
   logic [31:0] unused_timeout_cycles;

   assign unused_timeout_cycles = TIMEOUT_CYCLES;
   assign stale                 = 1'b0;
   assign tmo_hit               = 1'b0;
   assign bus.s_axil_bready     = (state_q == WAIT_SLV) ? sel_mask : '0;
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      resp_d  = resp_q;
      unique case (state_q)
         IDLE: begin
            if (bus.wr_start) begin
               if (enc_any) begin
                  sel_d   = enc_idx;
                  state_d = WAIT_SLV;
               end else begin
                  resp_d  = DECERR;
                  state_d = RESP;
               end
            end
         end
         WAIT_SLV: begin
            if (accept) begin
               resp_d  = resp_t'(bus.s_axil_bresp[sel_q]);
               state_d = RESP;
            end else if (tmo_hit) begin
               resp_d  = SLVERR;
               state_d = RESP;
            end
         end
         RESP: begin
            if (bus.m_axil_bready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         sel_q   <= '0;
         resp_q  <= OKAY;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         resp_q  <= resp_d;
      end
   end

   // Master outputs come straight from registers: no slave-to-master comb path.
   assign bus.busy          = (state_q != IDLE);
   assign bus.m_axil_bvalid = (state_q == RESP);
   assign bus.m_axil_bresp  = resp_q;

   // wr_start while busy is dropped by the FSM (only decoded in IDLE).
   a_no_start_when_busy: assert property (
      @(posedge aclk) disable iff (!aresetn) !(bus.wr_start && bus.busy)
   );

endmodule

// File: tb/tb_axil_wr_resp_router.sv
module tb_axil_wr_resp_router;
   import axil_pkg::*;

   localparam int unsigned N = 4;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;

   axil_wr_resp_router_if #(.NUMBER_SLAVE(N)) bus ();

   axil_wr_resp_router #(.NUMBER_SLAVE(N), .TIMEOUT_CYCLES(8)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]      slv_valid;
      int              delay;
      logic [3:0]      noise;
      logic [3:0][1:0] bresp;
      logic [3:0]      exp_rdy;
      logic [1:0]      exp_resp;
   } vec_t;

   vec_t vecs[6];

   // One complete write: issue, optional wait with non-selected noise, accept, return.
   task automatic run_vec(input vec_t v, input int n);
      string tag;
      tag = $sformatf("vec%0d", n);
      @(negedge aclk);
      bus.wr_start      = 1'b1;
      bus.slv_valid     = v.slv_valid;
      bus.s_axil_bresp  = v.bresp;
      bus.m_axil_bready = 1'b1;
      @(negedge aclk);
      bus.wr_start  = 1'b0;
      bus.slv_valid = '0;
      if (v.exp_rdy == 4'b0000) begin
         check({tag, " decerr bvalid"}, 32'(bus.m_axil_bvalid), 1);
         check({tag, " decerr bresp"}, 32'(bus.m_axil_bresp), 32'(v.exp_resp));
         check({tag, " decerr bready"}, 32'(bus.s_axil_bready), 0);
         check({tag, " decerr busy"}, 32'(bus.busy), 1);
      end else begin
         bus.s_axil_bvalid = v.noise & ~v.exp_rdy;
         for (int d = 0; d < v.delay; d++) begin
            check({tag, " wait bready"}, 32'(bus.s_axil_bready), 32'(v.exp_rdy));
            check({tag, " wait bvalid"}, 32'(bus.m_axil_bvalid), 0);
            @(negedge aclk);
         end
         bus.s_axil_bvalid = v.noise | v.exp_rdy;
         check({tag, " accept bready"}, 32'(bus.s_axil_bready), 32'(v.exp_rdy));
         @(negedge aclk);
         bus.s_axil_bvalid = '0;
         check({tag, " resp bvalid"}, 32'(bus.m_axil_bvalid), 1);
         check({tag, " resp bresp"}, 32'(bus.m_axil_bresp), 32'(v.exp_resp));
         check({tag, " resp bready"}, 32'(bus.s_axil_bready), 0);
      end
      @(negedge aclk);
      check({tag, " done busy"}, 32'(bus.busy), 0);
      check({tag, " done bvalid"}, 32'(bus.m_axil_bvalid), 0);
   endtask

   initial begin
      bus.wr_start      = 1'b0;
      bus.slv_valid     = '0;
      bus.s_axil_bvalid = '0;
      bus.s_axil_bresp  = '0;
      bus.m_axil_bready = 1'b0;

      //          slv_valid delay noise    bresp(s3 s2 s1 s0)  exp_rdy  exp_resp
      vecs[0] = '{4'b0000, 0, 4'b0000, 8'b00_00_00_00, 4'b0000, 2'b11};
      vecs[1] = '{4'b0100, 3, 4'b0000, 8'b11_00_11_11, 4'b0100, 2'b00};
      vecs[2] = '{4'b1010, 2, 4'b1101, 8'b10_01_00_11, 4'b0010, 2'b00};
      vecs[3] = '{4'b0001, 0, 4'b0000, 8'b00_00_00_01, 4'b0001, 2'b01};
      vecs[4] = '{4'b1000, 1, 4'b0111, 8'b10_00_01_11, 4'b1000, 2'b10};
      vecs[5] = '{4'b1111, 1, 4'b1110, 8'b01_10_01_11, 4'b0001, 2'b11};

      // Reset state
      repeat (2) @(negedge aclk);
      check("reset busy", 32'(bus.busy), 0);
      check("reset bvalid", 32'(bus.m_axil_bvalid), 0);
      check("reset bresp", 32'(bus.m_axil_bresp), 0);
      check("reset bready", 32'(bus.s_axil_bready), 0);
      aresetn = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Back-to-back DECERR writes at the minimum 2-cycle interval
      @(negedge aclk);
      bus.wr_start      = 1'b1;
      bus.slv_valid     = '0;
      bus.m_axil_bready = 1'b1;
      @(negedge aclk);
      bus.wr_start = 1'b0;
      check("b2b first bvalid", 32'(bus.m_axil_bvalid), 1);
      @(negedge aclk);
      check("b2b idle busy", 32'(bus.busy), 0);
      bus.wr_start = 1'b1;
      @(negedge aclk);
      bus.wr_start = 1'b0;
      check("b2b second bvalid", 32'(bus.m_axil_bvalid), 1);
      check("b2b second bresp", 32'(bus.m_axil_bresp), 'b11);
      @(negedge aclk);
      check("b2b second done", 32'(bus.busy), 0);

      // Backpressure: routed SLVERR held while master bready is low
      bus.m_axil_bready = 1'b0;
      bus.s_axil_bresp  = 8'b00_00_10_00;
      bus.wr_start      = 1'b1;
      bus.slv_valid     = 4'b0010;
      @(negedge aclk);
      bus.wr_start      = 1'b0;
      bus.slv_valid     = '0;
      bus.s_axil_bvalid = 4'b0010;
      @(negedge aclk);
      bus.s_axil_bvalid = '0;
      for (int i = 0; i < 5; i++) begin
         check("bp bvalid held", 32'(bus.m_axil_bvalid), 1);
         check("bp bresp held", 32'(bus.m_axil_bresp), 'b10);
         @(negedge aclk);
      end
      bus.m_axil_bready = 1'b1;
      @(negedge aclk);
      check("bp released busy", 32'(bus.busy), 0);
      check("bp released bvalid", 32'(bus.m_axil_bvalid), 0);

      // Reset while in WAIT_SLV
      bus.wr_start  = 1'b1;
      bus.slv_valid = 4'b0001;
      @(negedge aclk);
      bus.wr_start  = 1'b0;
      bus.slv_valid = '0;
      check("rst wait bready pre", 32'(bus.s_axil_bready), 'b0001);
      #2 aresetn = 1'b0;
      #1;
      check("rst wait bready", 32'(bus.s_axil_bready), 0);
      check("rst wait busy", 32'(bus.busy), 0);
      check("rst wait bvalid", 32'(bus.m_axil_bvalid), 0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Reset while in RESP
      bus.m_axil_bready = 1'b0;
      bus.wr_start      = 1'b1;
      @(negedge aclk);
      bus.wr_start = 1'b0;
      check("rst resp bvalid pre", 32'(bus.m_axil_bvalid), 1);
      #2 aresetn = 1'b0;
      #1;
      check("rst resp bvalid", 32'(bus.m_axil_bvalid), 0);
      check("rst resp bresp", 32'(bus.m_axil_bresp), 0);
      check("rst resp busy", 32'(bus.busy), 0);
      @(negedge aclk);
      aresetn = 1'b1;

      run_vec(vecs[0], 10);

`ifdef AXIL_WR_RESP_TIMEOUT_EN
      // Silent slave 0: SLVERR after 8 WAIT_SLV cycles, late bvalid drained
      @(negedge aclk);
      bus.m_axil_bready = 1'b1;
      bus.s_axil_bresp  = '0;
      bus.wr_start      = 1'b1;
      bus.slv_valid     = 4'b0001;
      @(negedge aclk);
      bus.wr_start  = 1'b0;
      bus.slv_valid = '0;
      for (int i = 0; i < 8; i++) begin
         check("tmo wait bvalid", 32'(bus.m_axil_bvalid), 0);
         @(negedge aclk);
      end
      check("tmo bvalid", 32'(bus.m_axil_bvalid), 1);
      check("tmo bresp", 32'(bus.m_axil_bresp), 'b10);
      check("tmo drain bready", 32'(bus.s_axil_bready), 'b0001);
      @(negedge aclk);
      bus.s_axil_bvalid = 4'b0001;
      check("tmo late idle bvalid", 32'(bus.m_axil_bvalid), 0);
      check("tmo late bready", 32'(bus.s_axil_bready), 'b0001);
      @(negedge aclk);
      bus.s_axil_bvalid = '0;
      check("tmo drained bready", 32'(bus.s_axil_bready), 0);
      check("tmo drained bvalid", 32'(bus.m_axil_bvalid), 0);
      check("tmo drained busy", 32'(bus.busy), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
